// File: rtl/lfsr_period_meter.sv
// Period meter for an external LFSR: loads a seed, lets the LFSR free-run and
// counts cycles until its output returns to the seed, or gives up at TIMEOUT.
module lfsr_period_meter #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] lfsr_val_i,
  output logic [WIDTH-1:0] lfsr_seed_o,
  output logic             lfsr_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] period_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;
  logic             timeout_q;
  logic             match;
  logic             expire;

  // At RUN entry the LFSR still shows the unstepped seed, so cnt==0 never matches.
  assign match  = (cnt != '0) && (lfsr_val_i == seed_q);
  assign expire = (cnt == TIMEOUT_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i)         state_next = RUN;
      RUN:     if (match || expire) state_next = DONE;
      DONE:                         state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      seed_q    <= '0;
      cnt       <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            seed_q    <= seed_i;
            cnt       <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
          end
        end
        RUN: begin
          // A match on the final counted cycle wins over the timeout.
          if (match) begin
            period_q <= cnt;
          end else if (expire) begin
            timeout_q <= 1'b1;
            period_q  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign lfsr_seed_o = seed_q;
  assign lfsr_en_o   = (state == RUN);
  assign busy_o      = (state == RUN);
  assign done_o      = (state == DONE);
  assign period_o    = period_q;
  assign timeout_o   = timeout_q;

endmodule
